// File: rtl/teras_result_reader.sv
// teras_result_reader: sink for the teras result stream (rts/rtr/data).
// Results are buffered in a FIFO and read by the management core through
// Wishbone registers: DATA (pop), STATUS, CTRL (flush / clear sticky flags).
// Optional feature macro TERAS_RDR_IRQ_EN: adds irq_o and a THRESH register
// at address slot 3; without it slot 3 reads 0 and ignores writes.
module teras_result_reader #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rts_i,
   output logic              rtr_o,
   input  logic [DATA_W-1:0] data_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_cyc_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
`ifdef TERAS_RDR_IRQ_EN
   output logic              irq_o,
`endif
   output logic              wbs_ack_o,
   output logic [31:0]       wbs_dat_o
);

   localparam int              PTR_W    = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [1:0]       A_DATA   = 2'd0;
   localparam logic [1:0]       A_STATUS = 2'd1;
   localparam logic [1:0]       A_CTRL   = 2'd2;
   localparam logic [1:0]       A_AUX    = 2'd3;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wptr_q, wptr_d;
   logic [PTR_W-1:0]  rptr_q, rptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              unf_q, unf_d;
   logic              drop_q, drop_d;
   logic [7:0]        stall_q, stall_d;
   logic              ack_q, ack_d;
   logic [31:0]       dat_q, dat_d;
   logic [31:0]       rdata;

   logic       full, empty, push, pop;
   logic       req, rd_req, wr_req;
   logic [1:0] adr;
   logic       unf_set, ctrl_wr, flush, clr, stall_hit, drop_set;

`ifdef TERAS_RDR_IRQ_EN
   logic [CNT_W-1:0] thresh_q, thresh_d;
   logic             irq_q, irq_d;
`endif

   // Full/empty come from the registered count only, so rtr_o never
   // depends combinationally on a pop in the same cycle.
   assign full      = (cnt_q == CNT_FULL);
   assign empty     = (cnt_q == '0);
   assign rtr_o     = rst_n & ~full;
   assign push      = rts_i & rtr_o;

   // A request is only taken while no ack is outstanding, which yields
   // one-cycle latency and ack every other cycle on back-to-back strobes.
   assign req       = wbs_cyc_i & wbs_stb_i & ~ack_q;
   assign rd_req    = req & ~wbs_we_i;
   assign wr_req    = req & wbs_we_i;
   assign adr       = wbs_adr_i[3:2];

   assign pop       = rd_req & (adr == A_DATA) & ~empty;
   assign unf_set   = rd_req & (adr == A_DATA) & empty;
   assign ctrl_wr   = wr_req & (adr == A_CTRL) & wbs_sel_i[0];
   assign flush     = ctrl_wr & wbs_dat_i[0];
   assign clr       = ctrl_wr & wbs_dat_i[1];
   assign stall_hit = rts_i & full;
   assign drop_set  = stall_hit & (stall_q == 8'hFF);

   logic unused_ok;
   assign unused_ok = ^{wbs_sel_i[3:1], wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:2]};

   // Pointer and occupancy update; flush overrides a concurrent push.
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (flush) begin
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
      end else begin
         if (push) wptr_d = wptr_q + PTR_W'(1);
         if (pop)  rptr_d = rptr_q + PTR_W'(1);
         cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Sticky flags (set beats clear) and saturating stall counter.
   always_comb begin
      unf_d   = (unf_q & ~clr) | unf_set;
      drop_d  = (drop_q & ~clr) | drop_set;
      stall_d = '0;
      if (stall_hit) stall_d = (stall_q == 8'hFF) ? 8'hFF : stall_q + 8'd1;
   end

   // Read mux evaluated against the state present when the request is seen.
   always_comb begin
      rdata = '0;
      case (adr)
         A_DATA: begin
            if (!empty) rdata[DATA_W-1:0] = mem[rptr_q];
         end
         A_STATUS: begin
            rdata[CNT_W-1:0] = cnt_q;
            rdata[16]        = empty;
            rdata[17]        = full;
            rdata[18]        = unf_q;
            rdata[19]        = drop_q;
         end
`ifdef TERAS_RDR_IRQ_EN
         A_AUX: rdata[CNT_W-1:0] = thresh_q;
`endif
         default: ;
      endcase
   end

   // Wishbone response: ack and data registered one cycle after the request.
   always_comb begin
      ack_d = req;
      dat_d = dat_q;
      if (req) dat_d = wbs_we_i ? 32'd0 : rdata;
   end

   // Control and response state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         unf_q   <= 1'b0;
         drop_q  <= 1'b0;
         stall_q <= '0;
         ack_q   <= 1'b0;
         dat_q   <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
         unf_q   <= unf_d;
         drop_q  <= drop_d;
         stall_q <= stall_d;
         ack_q   <= ack_d;
         dat_q   <= dat_d;
      end
   end

   // FIFO storage holds data only, so it carries no reset.
   always_ff @(posedge clk) begin
      if (push) mem[wptr_q] <= data_i;
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;

`ifdef TERAS_RDR_IRQ_EN
   // Threshold register write and level interrupt from the registered count.
   always_comb begin
      thresh_d = thresh_q;
      if (wr_req && (adr == A_AUX) && wbs_sel_i[0]) thresh_d = wbs_dat_i[CNT_W-1:0];
      irq_d = (cnt_q >= thresh_q) && (thresh_q != '0);
   end

   // Threshold resets to 1 so the interrupt means "not empty" by default.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         thresh_q <= CNT_W'(1);
         irq_q    <= 1'b0;
      end else begin
         thresh_q <= thresh_d;
         irq_q    <= irq_d;
      end
   end

   assign irq_o = irq_q;
`endif

endmodule

// File: doc/teras_result_reader.md
Name: teras_result_reader

Overview:
- Sink for the teras array master-side result stream (rts/rtr/data handshake).
- Buffers results in an internal FIFO and exposes them to the Caravel management core as Wishbone slave registers.
- Closes the loop with the input bridge: the host writes operands in and reads matrix C results back over the same bus.

Parameters:
- DATA_W, 32, width of the teras result word (1..32); zero-extended onto wbs_dat_o.
- DEPTH, 16, FIFO entries; power of two, 2..64.
- CNT_W, 5, count width; must equal log2(DEPTH)+1.

Ports:
- clk  input  1  system clock (driven from wb_clk_i at top level)
- rst_n  input  1  asynchronous active-low reset
- rts_i  input  1  teras result valid (ready-to-send)
- rtr_o  output  1  ready-to-receive back to teras
- data_i  input  DATA_W  teras result word
- wbs_stb_i  input  1  Wishbone strobe
- wbs_cyc_i  input  1  Wishbone cycle
- wbs_we_i  input  1  Wishbone write enable
- wbs_sel_i  input  4  byte selects; only bit 0 is used, for CTRL writes
- wbs_adr_i  input  32  address; only bits [3:2] are decoded
- wbs_dat_i  input  32  write data
- wbs_ack_o  output  1  Wishbone acknowledge
- wbs_dat_o  output  32  read data

Behaviour:
- Reset (async, rst_n low): FIFO empty, count 0, read and write pointers 0, sticky flags 0, wbs_ack_o 0, wbs_dat_o 0. rtr_o is 1 as soon as reset is released; it reads 0 only while rst_n is low.
- Stream push:
  - rtr_o = !full, computed from registered count only; it is not combinational on any pop.
  - Transfer occurs on a rising edge when rts_i && rtr_o: data_i is written at the write pointer and the pointer advances, wrapping at DEPTH.
  - When full, rtr_o = 0 even if a pop happens in the same cycle.
- Wishbone request:
  - req = wbs_cyc_i && wbs_stb_i && !wbs_ack_o.
  - On req, the next edge registers wbs_ack_o = 1 and wbs_dat_o. The cycle after that, wbs_ack_o = 0.
  - Latency is exactly 1 cycle; ack is never held for 2 cycles; back-to-back requests are acked every other cycle.
- Register map (adr[3:2]):
  - 0 DATA (read-only): returns the FIFO head zero-extended and pops it on the ack edge. When empty, returns 0, no pop, and sets sticky underflow.
  - 1 STATUS (read-only): [CNT_W-1:0] = count, [16] = empty, [17] = full, [18] = underflow sticky, [19] = drop sticky.
  - 2 CTRL (write-only; reads return 0), applied on the ack edge when wbs_sel_i[0]:
    - bit0 = flush: pointers and count go to 0.
    - bit1 = clear sticky flags.
  - 3: reads return 0; writes are ignored. Still acked.
  - Writes to DATA/STATUS are ignored but acked.
- Drop flag: set if rts_i is high while full for more than 255 consecutive cycles (8-bit stall counter, saturating). Diagnostic only; no data is lost.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Flush with a simultaneous push: flush wins; the pushed word is discarded and count = 0.
- Sticky clear with a simultaneous set event: set wins.
- Count arithmetic: CNT_W bits, never exceeds DEPTH, never goes negative.
- Reset mid-transaction: a pending ack is dropped and FIFO contents are lost. The master must retry after reset.

Optional Feature:
- Macro TERAS_RDR_IRQ_EN.
- Defined:
  - Adds output port irq_o (1 bit) and register 3 as THRESH (read/write, CNT_W bits, reset value 1).
  - irq_o is registered: 1 when count >= THRESH and THRESH != 0. Reset value 0.
- Undefined: no irq_o port; register 3 reads 0 and ignores writes.

Test Plan:
- Reset then idle: rtr_o = 1, STATUS read returns 0x0001_0000 with ack exactly 1 cycle after stb.
- Push 0xA1, 0xB2, 0xC3, then three DATA reads: returns A1, B2, C3 in order; STATUS count 0, empty = 1.
- Hold rts_i high with DATA_W-wide incrementing data for 20 cycles, DEPTH = 16: rtr_o drops after 16 accepts; reading 16 words returns 0..15; words 16..19 follow with no gap or duplicate. Continue stalling 256 cycles to check drop = 1.
- DATA read while empty: returns 0, STATUS underflow = 1. CTRL write 0x2: underflow = 0.
- Full FIFO, push held and DATA read in the same cycle: rtr_o stays 0 that cycle; the next cycle rtr_o = 1 and count returns to 16 after the push.
- CTRL flush (0x1) with wbs_sel_i = 0x1 while count = 5 and a concurrent push: count = 0, empty = 1. With TERAS_RDR_IRQ_EN and THRESH = 3, pushing 3 words makes irq_o = 1 the cycle after count reaches 3.
